// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the UART command sequencer:
//     state_t       - frame parser / commit state encoding
//     BYTE_W        - width of every byte-wide path
//     SYNC_DEFAULT  - default frame start marker
//     ERR_CNT_MAX   - saturation value of the error counter
//     sat_inc()     - saturating increment for the error counter
package uart_cmd_pkg;

   localparam int unsigned       BYTE_W       = 8;
   localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;
   localparam logic [BYTE_W-1:0] ERR_CNT_MAX  = 8'hFF;

   typedef enum logic [2:0] {
      HUNT,
      ADDR,
      LEN,
      PAYLOAD,
      CHECK,
      COMMIT
   } state_t;

   function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf
//   Payload buffer: DEPTH x BYTE_W register array, one synchronous write
//   port and one combinational read port. Storage has no reset; entries are
//   only read after the parser has written them for the current frame.
//   Ports:
//     CLK50MHz  in   clock
//     we        in   write enable
//     widx      in   write index
//     wdata     in   write data
//     ridx      in   read index
//     rdata     out  read data (combinational)
module uart_cmd_buf
   import uart_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
)(
   input  logic              CLK50MHz,
   input  logic              we,
   input  logic [AW-1:0]     widx,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [AW-1:0]     ridx,
   output logic [BYTE_W-1:0] rdata
);

   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK50MHz) begin
      if (we) mem[widx] <= wdata;
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Turns the UART receive byte stream into checked register-write bursts.
//   Frame: SYNC, addr, len (1..MAX_LEN), len payload bytes, XOR checksum of
//   addr^len^payload. The payload is buffered and replayed as a handshaked
//   write burst only when the checksum matches.
//   Optional build macro: UART_CMD_TIMEOUT_EN adds an inter-byte silence
//   timeout (TIMEOUT_CYC) that aborts a frame still being received.
//   Ports:
//     CLK50MHz   in   clock
//     RESET      in   async active-low reset
//     RX_DATA    in   received byte (valid with RX_VALID)
//     RX_VALID   in   one-cycle byte strobe
//     RX_PERR    in   parity error for the strobed byte
//     WR_EN      out  write request, held until accepted
//     WR_ADDR    out  register address (base + index, 8-bit wrap)
//     WR_DATA    out  register data
//     WR_READY   in   write accepted when WR_EN && WR_READY
//     FRAME_OK   out  pulse after last write of a good frame is accepted
//     FRAME_ERR  out  pulse on any frame abort
//     OVERRUN    out  pulse when a byte is dropped during commit
//     ERR_CNT    out  saturating count of FRAME_ERR pulses
//     BUSY       out  high whenever not hunting for sync
module uart_cmd_sequencer
   import uart_cmd_pkg::*;
#(
   parameter int unsigned       MAX_LEN   = 8,
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
   , parameter int unsigned     TIMEOUT_CYC = 286000
`endif
)(
   input  logic              CLK50MHz,
   input  logic              RESET,
   input  logic [BYTE_W-1:0] RX_DATA,
   input  logic              RX_VALID,
   input  logic              RX_PERR,
   output logic              WR_EN,
   output logic [BYTE_W-1:0] WR_ADDR,
   output logic [BYTE_W-1:0] WR_DATA,
   input  logic              WR_READY,
   output logic              FRAME_OK,
   output logic              FRAME_ERR,
   output logic              OVERRUN,
   output logic [BYTE_W-1:0] ERR_CNT,
   output logic              BUSY
);

   // CW holds a length (0..MAX_LEN); AW addresses the buffer (0..MAX_LEN-1)
   localparam int unsigned       CW        = $clog2(MAX_LEN + 1);
   localparam int unsigned       AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

   state_t            state;
   logic [BYTE_W-1:0] base;
   logic [BYTE_W-1:0] csum;
   logic [CW-1:0]     len;
   logic [CW-1:0]     idx;

   logic              byte_ok;
   logic              abort;
   logic              tmo_hit;
   logic              last_acc;
   logic              buf_we;
   logic [AW-1:0]     buf_widx;
   logic [AW-1:0]     buf_ridx;
   logic [BYTE_W-1:0] buf_rdata;

   assign byte_ok  = RX_VALID && !RX_PERR;
   assign last_acc = (idx == len - 1'b1);
   assign BUSY     = (state != HUNT);

   assign buf_we   = (state == PAYLOAD) && byte_ok;
   assign buf_widx = idx[AW-1:0];
   // Read one entry ahead during commit so the next WR_DATA is ready at the
   // accept edge; outside commit, entry 0 is presented for the first write.
   assign buf_ridx = (state == COMMIT) ? AW'(idx + 1'b1) : '0;

   uart_cmd_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .CLK50MHz (CLK50MHz),
      .we       (buf_we),
      .widx     (buf_widx),
      .wdata    (RX_DATA),
      .ridx     (buf_ridx),
      .rdata    (buf_rdata)
   );

`ifdef UART_CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tcnt;
   logic          counting;

   assign counting = state inside {ADDR, LEN, PAYLOAD, CHECK};
   assign tmo_hit  = counting && !RX_VALID && (tcnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK50MHz or negedge RESET) begin
      if (!RESET)                             tcnt <= '0;
      else if (RX_VALID || !counting || tmo_hit) tcnt <= '0;
      else                                    tcnt <= tcnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Abort sources: parity error mid-frame, bad length, checksum mismatch,
   // silence timeout. None of them can fire in HUNT or COMMIT.
   always_comb begin
      abort = 1'b0;
      if (RX_VALID && RX_PERR && (state inside {ADDR, LEN, PAYLOAD, CHECK}))
         abort = 1'b1;
      else if (byte_ok) begin
         case (state)
            LEN:     abort = (RX_DATA == '0) || (RX_DATA > MAX_LEN_B);
            CHECK:   abort = (RX_DATA != csum);
            default: abort = 1'b0;
         endcase
      end
      if (tmo_hit) abort = 1'b1;
   end

   always_ff @(posedge CLK50MHz or negedge RESET) begin
      if (!RESET) begin
         state     <= HUNT;
         base      <= '0;
         csum      <= '0;
         len       <= '0;
         idx       <= '0;
         WR_EN     <= 1'b0;
         WR_ADDR   <= '0;
         WR_DATA   <= '0;
         FRAME_OK  <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
         ERR_CNT   <= '0;
      end else begin
         FRAME_OK  <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
         if (abort) begin
            state     <= HUNT;
            idx       <= '0;
            FRAME_ERR <= 1'b1;
            ERR_CNT   <= sat_inc(ERR_CNT);
         end else begin
            case (state)
               HUNT: begin
                  if (byte_ok && RX_DATA == SYNC_BYTE) state <= ADDR;
               end
               ADDR: begin
                  if (byte_ok) begin
                     base  <= RX_DATA;
                     csum  <= RX_DATA;
                     state <= LEN;
                  end
               end
               LEN: begin
                  if (byte_ok) begin
                     len   <= CW'(RX_DATA);
                     csum  <= csum ^ RX_DATA;
                     idx   <= '0;
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  if (byte_ok) begin
                     csum <= csum ^ RX_DATA;
                     idx  <= idx + 1'b1;
                     if (idx + 1'b1 == len) state <= CHECK;
                  end
               end
               CHECK: begin
                  if (byte_ok) begin
                     state   <= COMMIT;
                     idx     <= '0;
                     WR_EN   <= 1'b1;
                     WR_ADDR <= base;
                     WR_DATA <= buf_rdata;
                  end
               end
               COMMIT: begin
                  // Bytes arriving now cannot be buffered; drop and flag.
                  if (RX_VALID) OVERRUN <= 1'b1;
                  if (WR_READY) begin
                     if (last_acc) begin
                        WR_EN    <= 1'b0;
                        FRAME_OK <= 1'b1;
                        idx      <= '0;
                        state    <= HUNT;
                     end else begin
                        idx     <= idx + 1'b1;
                        WR_ADDR <= WR_ADDR + 1'b1;
                        WR_DATA <= buf_rdata;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
//   Scenario tasks drive UART frames; expected writes are queued when a good
//   frame is sent and popped by a monitor on every accepted write.
module tb_uart_cmd_sequencer;

   localparam logic [7:0] SYNC  = 8'hA5;
   localparam int         T_CYC = 3000;

   logic       CLK50MHz = 1'b0;
   logic       RESET    = 1'b0;
   logic [7:0] RX_DATA  = 8'h00;
   logic       RX_VALID = 1'b0;
   logic       RX_PERR  = 1'b0;
   logic       WR_READY = 1'b0;
   logic       WR_EN;
   logic [7:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       FRAME_OK;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic [7:0] ERR_CNT;
   logic       BUSY;

   int total = 0;
   int bad   = 0;
   int ok_seen = 0, err_seen = 0, ov_seen = 0, wr_seen = 0;
   int exp_err = 0;

   logic [15:0] sb[$];
   logic [7:0]  pl[$];

   always #10 CLK50MHz = ~CLK50MHz;

   uart_cmd_sequencer #(
      .MAX_LEN   (8),
      .SYNC_BYTE (SYNC)
`ifdef UART_CMD_TIMEOUT_EN
      , .TIMEOUT_CYC (T_CYC)
`endif
   ) dut (
      .CLK50MHz  (CLK50MHz),
      .RESET     (RESET),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .RX_PERR   (RX_PERR),
      .WR_EN     (WR_EN),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .WR_READY  (WR_READY),
      .FRAME_OK  (FRAME_OK),
      .FRAME_ERR (FRAME_ERR),
      .OVERRUN   (OVERRUN),
      .ERR_CNT   (ERR_CNT),
      .BUSY      (BUSY)
   );

   // Samples 2 time units after each falling edge: inputs driven on the
   // falling edge are settled and hold through the next rising edge.
   task automatic monitor();
      logic        stall_q = 1'b0;
      logic [7:0]  a_q = 8'h00, d_q = 8'h00;
      logic [15:0] exp;
      forever begin
         @(negedge CLK50MHz); #2;
         if (!RESET) stall_q = 1'b0;
         else begin
            if (FRAME_OK)  ok_seen++;
            if (FRAME_ERR) err_seen++;
            if (OVERRUN)   ov_seen++;
            if (WR_EN)     wr_seen++;
            if (FRAME_OK || FRAME_ERR) begin
               total++;
               if (FRAME_OK && FRAME_ERR) begin
                  bad++; $display("FAIL ok_err_exclusive: both high at %0t", $time);
               end
            end
            if (stall_q) begin
               total++;
               if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, a_q, d_q}) begin
                  bad++;
                  $display("FAIL stall_stable: got en=%0b %02h/%02h want 1 %02h/%02h",
                           WR_EN, WR_ADDR, WR_DATA, a_q, d_q);
               end
            end
            if (WR_EN && WR_READY) begin
               total++;
               if (sb.size() == 0) begin
                  bad++; $display("FAIL write_unexpected: got %02h/%02h want none", WR_ADDR, WR_DATA);
               end else begin
                  exp = sb.pop_front();
                  if ({WR_ADDR, WR_DATA} !== exp) begin
                     bad++;
                     $display("FAIL write_data: got %02h/%02h want %02h/%02h",
                              WR_ADDR, WR_DATA, exp[15:8], exp[7:0]);
                  end
               end
            end
            stall_q = WR_EN && !WR_READY;
            a_q = WR_ADDR;
            d_q = WR_DATA;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic pe);
      @(negedge CLK50MHz);
      RX_DATA = b; RX_VALID = 1'b1; RX_PERR = pe;
      @(negedge CLK50MHz);
      RX_VALID = 1'b0; RX_PERR = 1'b0;
   endtask

   // Sends SYNC, addr, len, pl[], checksum^flip. Good frames queue their writes.
   task automatic send_frame(input logic [7:0] a, input logic [7:0] flip, input bit push_wr);
      logic [7:0] cs;
      logic [7:0] l;
      l  = 8'(pl.size());
      cs = a ^ l;
      foreach (pl[i]) cs ^= pl[i];
      if (push_wr) foreach (pl[i]) sb.push_back({a + 8'(i), pl[i]});
      send_byte(SYNC, 1'b0);
      send_byte(a, 1'b0);
      send_byte(l, 1'b0);
      foreach (pl[i]) send_byte(pl[i], 1'b0);
      send_byte(cs ^ flip, 1'b0);
   endtask

   task automatic wait_frame_ok(input string name);
      int ok0 = ok_seen;
      int n   = 0;
      while (ok_seen == ok0 && n < 200) begin @(negedge CLK50MHz); #3; n++; end
      total++;
      if (ok_seen == ok0) begin bad++; $display("FAIL %s: FRAME_OK not seen in 200 cycles", name); end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL %s: %0d writes missing, want 0", name, sb.size()); end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      repeat (3) @(negedge CLK50MHz);
      total++;
      if ({WR_EN, WR_ADDR, WR_DATA, FRAME_OK, FRAME_ERR, OVERRUN, ERR_CNT, BUSY} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: en=%0b a=%02h d=%02h ok=%0b err=%0b ov=%0b cnt=%0d busy=%0b want all 0",
                  WR_EN, WR_ADDR, WR_DATA, FRAME_OK, FRAME_ERR, OVERRUN, ERR_CNT, BUSY);
      end
      RESET = 1'b1;
      @(negedge CLK50MHz);
   endtask

   task automatic test_good_frame();
      int n = 0;
      WR_READY = 1'b1;
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, 8'h00, 1'b1);
      #2;
      total++;
      if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 8'h10, 8'h11}) begin
         bad++; $display("FAIL good_first_write: en=%0b %02h/%02h want 1 10/11", WR_EN, WR_ADDR, WR_DATA);
      end
      while (!FRAME_OK && n < 20) begin @(negedge CLK50MHz); #2; n++; end
      total++;
      if (n != 3) begin bad++; $display("FAIL good_latency: FRAME_OK after %0d cycles want 3", n); end
      @(negedge CLK50MHz); #3;
      total++;
      if ({ERR_CNT, BUSY, WR_EN} !== {8'd0, 1'b0, 1'b0} || sb.size() != 0) begin
         bad++; $display("FAIL good_after: cnt=%0d busy=%0b en=%0b left=%0d want 0 0 0 0",
                         ERR_CNT, BUSY, WR_EN, sb.size());
      end
   endtask

   task automatic test_bad_csum();
      int w0 = wr_seen;
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, 8'h01, 1'b0);
      #2;
      exp_err++;
      total++;
      if ({FRAME_ERR, ERR_CNT, BUSY} !== {1'b1, 8'(exp_err), 1'b0}) begin
         bad++; $display("FAIL bad_csum: err=%0b cnt=%0d busy=%0b want 1 %0d 0", FRAME_ERR, ERR_CNT, BUSY, exp_err);
      end
      repeat (3) @(negedge CLK50MHz); #3;
      total++;
      if (wr_seen != w0) begin bad++; $display("FAIL bad_csum_nowrite: %0d WR_EN cycles want 0", wr_seen - w0); end
   endtask

   task automatic test_hunt_ignore();
      int e0 = err_seen;
      send_byte(8'h33, 1'b0);
      send_byte(SYNC, 1'b1);
      send_byte(8'h10, 1'b0);
      #3;
      total++;
      if (BUSY !== 1'b0 || err_seen != e0 || ERR_CNT !== 8'(exp_err)) begin
         bad++; $display("FAIL hunt_ignore: busy=%0b errs=%0d cnt=%0d want 0 0 %0d", BUSY, err_seen - e0, ERR_CNT, exp_err);
      end
   endtask

   task automatic test_stall_wrap();
      WR_READY = 1'b0;
      pl = '{8'hAA, 8'hBB};
      send_frame(8'hFF, 8'h00, 1'b1);
      for (int w = 0; w < 2; w++) begin
         repeat (3) @(negedge CLK50MHz);
         WR_READY = 1'b1;
         @(negedge CLK50MHz);
         WR_READY = 1'b0;
      end
      wait_frame_ok("stall_wrap");
   endtask

   task automatic test_overrun();
      int o0 = ov_seen;
      WR_READY = 1'b0;
      pl = '{8'h01, 8'h02};
      send_frame(8'h20, 8'h00, 1'b1);
      send_byte(8'h77, 1'b0);
      #3;
      total++;
      if (ov_seen - o0 != 1 || ERR_CNT !== 8'(exp_err) || WR_EN !== 1'b1) begin
         bad++; $display("FAIL overrun: pulses=%0d cnt=%0d en=%0b want 1 %0d 1", ov_seen - o0, ERR_CNT, WR_EN, exp_err);
      end
      @(negedge CLK50MHz);
      WR_READY = 1'b1;
      wait_frame_ok("overrun_commit");
   endtask

   task automatic test_aborts();
      int e0;
      logic [7:0] seq [3][4];
      seq[0] = '{SYNC, 8'h10, 8'h00, 8'h00};
      seq[1] = '{SYNC, 8'h10, 8'h09, 8'h00};
      seq[2] = '{SYNC, 8'h10, 8'h02, 8'h11};
      for (int k = 0; k < 3; k++) begin
         e0 = err_seen;
         send_byte(seq[k][0], 1'b0);
         send_byte(seq[k][1], 1'b0);
         send_byte(seq[k][2], 1'b0);
         if (k == 2) send_byte(seq[k][3], 1'b1);
         #3;
         exp_err++;
         total++;
         if (err_seen - e0 != 1 || ERR_CNT !== 8'(exp_err) || BUSY !== 1'b0) begin
            bad++; $display("FAIL abort_%0d: pulses=%0d cnt=%0d busy=%0b want 1 %0d 0",
                            k, err_seen - e0, ERR_CNT, BUSY, exp_err);
         end
      end
      for (int k = 0; k < 300; k++) begin
         send_byte(SYNC, 1'b0);
         send_byte(8'h10, 1'b0);
         send_byte(8'h00, 1'b0);
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      end
      #3;
      total++;
      if (ERR_CNT !== 8'd255 || exp_err != 255) begin
         bad++; $display("FAIL err_saturate: cnt=%0d want 255", ERR_CNT);
      end
   endtask

   task automatic test_reset_commit();
      int w0;
      WR_READY = 1'b0;
      pl = '{8'h44};
      send_frame(8'h30, 8'h00, 1'b1);
      #5;
      RESET = 1'b0;
      #1;
      total++;
      if ({WR_EN, BUSY, ERR_CNT} !== '0) begin
         bad++; $display("FAIL reset_commit: en=%0b busy=%0b cnt=%0d want 0 0 0", WR_EN, BUSY, ERR_CNT);
      end
      sb.delete();
      exp_err = 0;
      repeat (2) @(negedge CLK50MHz);
      RESET = 1'b1;
      WR_READY = 1'b1;
      w0 = wr_seen;
      repeat (10) @(negedge CLK50MHz); #3;
      total++;
      if (wr_seen != w0 || BUSY !== 1'b0) begin
         bad++; $display("FAIL reset_commit_after: %0d WR_EN cycles busy=%0b want 0 0", wr_seen - w0, BUSY);
      end
   endtask

   task automatic test_silence();
      int e0 = err_seen;
      int n  = 0;
      send_byte(SYNC, 1'b0);
      send_byte(8'h10, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
      while (err_seen == e0 && n < T_CYC + 20) begin @(negedge CLK50MHz); #3; n++; end
      exp_err++;
      total++;
      if (err_seen == e0 || n < T_CYC - 5 || n > T_CYC + 5) begin
         bad++; $display("FAIL timeout: pulses=%0d after %0d cycles want 1 near %0d", err_seen - e0, n, T_CYC);
      end
      total++;
      if (BUSY !== 1'b0 || ERR_CNT !== 8'(exp_err)) begin
         bad++; $display("FAIL timeout_state: busy=%0b cnt=%0d want 0 %0d", BUSY, ERR_CNT, exp_err);
      end
`else
      repeat (2 * T_CYC) @(negedge CLK50MHz);
      #3;
      n = err_seen - e0;
      total++;
      if (n != 0 || BUSY !== 1'b1) begin
         bad++; $display("FAIL no_timeout: pulses=%0d busy=%0b want 0 1", n, BUSY);
      end
      // Finish the stalled frame: len 1, payload 5A, csum 10^01^5A.
      sb.push_back({8'h10, 8'h5A});
      send_byte(8'h01, 1'b0);
      send_byte(8'h5A, 1'b0);
      send_byte(8'h4B, 1'b0);
      wait_frame_ok("no_timeout_resume");
`endif
   endtask

   initial begin
      fork monitor(); join_none
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_hunt_ignore();
      test_stall_wrap();
      test_overrun();
      test_aborts();
      test_reset_commit();
      test_silence();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
